// File: rtl/pix_arb_pkg.sv
// rtl/pix_arb_pkg.sv - shared state encoding and requester indices for the pixel RAM arbiter
package pix_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } arb_state_t;

   localparam int REQ_LOAD  = 0;
   localparam int REQ_CONV  = 1;
   localparam int REQ_MAXP  = 2;
   localparam int REQ_DENSE = 3;
   localparam int REQ_RES   = 4;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin first-set finder
// Scans req upward from ptr, wrapping at N_REQ-1 back to 0.
module rr_pick #(
   parameter int N_REQ = 5,
   parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic             found,
   output logic [PW-1:0]    idx
);

   localparam int CW = PW + 1;

   logic [CW-1:0] w_cand;

   always_comb begin
      found  = 1'b0;
      idx    = '0;
      w_cand = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_cand = {1'b0, ptr} + CW'(k);
         if (w_cand >= CW'(N_REQ))
            w_cand = w_cand - CW'(N_REQ);
         if (!found && req[w_cand[PW-1:0]]) begin
            found = 1'b1;
            idx   = w_cand[PW-1:0];
         end
      end
   end

endmodule

// File: rtl/pix_port_arbiter.sv
// rtl/pix_port_arbiter.sv - round-robin req/gnt arbiter for the shared pixel RAM port pair
// Ownership is registered; a one-cycle turnaround separates consecutive owners.
module pix_port_arbiter
   import pix_arb_pkg::*;
#(
   parameter int N_REQ            = 5,
   parameter int SIZE_1           = 11,
   parameter int SIZE_address_pix = 13,
   parameter int MAX_HOLD         = 0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [N_REQ-1:0]                  req,
   output logic [N_REQ-1:0]                  gnt,
   input  logic [N_REQ-1:0]                  we_in,
   input  logic [N_REQ-1:0]                  re_in,
   input  logic [N_REQ*SIZE_address_pix-1:0] waddr_in,
   input  logic [N_REQ*SIZE_address_pix-1:0] raddr_in,
   input  logic [N_REQ*SIZE_1-1:0]           dp_in,
   output logic                              we_p,
   output logic                              re_p,
   output logic [SIZE_address_pix-1:0]       write_addressp,
   output logic [SIZE_address_pix-1:0]       read_addressp,
   output logic [SIZE_1-1:0]                 dp,
   output logic                              busy,
   output logic                              viol,
   output logic [2:0]                        viol_id,
   output logic                              timeout,
   input  logic                              clear_err
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
   localparam int A  = SIZE_address_pix;
   localparam int D  = SIZE_1;

   arb_state_t       r_state;
   logic [N_REQ-1:0] r_gnt;
   logic [PW-1:0]    r_owner;
   logic [PW-1:0]    r_ptr;
   logic [HW-1:0]    r_hold;
   logic             r_busy;
   logic             r_viol;
   logic [2:0]       r_viol_id;
   logic             r_timeout;

   logic             w_found;
   logic [PW-1:0]    w_win;
   logic             w_en;
   logic [A-1:0]     w_waddr;
   logic [A-1:0]     w_raddr;
   logic [D-1:0]     w_dp;
   logic             w_viol_hit;
   logic [2:0]       w_viol_idx;
   logic             w_to;

   rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
      .req   (req),
      .ptr   (r_ptr),
      .found (w_found),
      .idx   (w_win)
   );

   assign w_en = r_busy & req[r_owner];

   always_comb begin
      w_waddr = '0;
      w_raddr = '0;
      w_dp    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_en && (r_owner == PW'(i))) begin
            w_waddr = waddr_in[i*A +: A];
            w_raddr = raddr_in[i*A +: A];
            w_dp    = dp_in[i*D +: D];
         end
      end
   end

   // Downward scan so the lowest-numbered violator is the one reported.
   always_comb begin
      w_viol_hit = 1'b0;
      w_viol_idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if ((we_in[i] | re_in[i]) && !(w_en && (r_owner == PW'(i)))) begin
            w_viol_hit = 1'b1;
            w_viol_idx = 3'(i);
         end
      end
   end

   assign w_to = (MAX_HOLD != 0) && r_busy && (r_hold >= HW'(MAX_HOLD)) && (|(req & ~r_gnt));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_gnt     <= '0;
         r_owner   <= '0;
         r_ptr     <= '0;
         r_hold    <= '0;
         r_busy    <= 1'b0;
         r_viol    <= 1'b0;
         r_viol_id <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (clear_err) begin
            r_viol    <= 1'b0;
            r_viol_id <= '0;
            r_timeout <= 1'b0;
         end else begin
            if (w_viol_hit && !r_viol) begin
               r_viol    <= 1'b1;
               r_viol_id <= w_viol_idx;
            end
            if (w_to)
               r_timeout <= 1'b1;
         end

         case (r_state)
            IDLE, TURN: begin
               if (w_found) begin
                  r_state <= GRANT;
                  r_gnt   <= N_REQ'(1) << w_win;
                  r_owner <= w_win;
                  r_hold  <= '0;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= IDLE;
               end
            end
            GRANT: begin
               if (req[r_owner]) begin
                  if (r_hold != '1)
                     r_hold <= r_hold + 1'b1;
               end else begin
                  r_state <= TURN;
                  r_gnt   <= '0;
                  r_busy  <= 1'b0;
                  r_ptr   <= (r_owner == PW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_gnt   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt            = r_gnt;
   assign busy           = r_busy;
   assign viol           = r_viol;
   assign viol_id        = r_viol_id;
   assign timeout        = r_timeout;
   assign we_p           = w_en & we_in[r_owner];
   assign re_p           = w_en & re_in[r_owner];
   assign write_addressp = w_waddr;
   assign read_addressp  = w_raddr;
   assign dp             = w_dp;

endmodule

// File: tb/tb_pix_port_arbiter.sv
// tb/tb_pix_port_arbiter.sv - self-checking bench for pix_port_arbiter with a behavioural ownership model
module tb_pix_port_arbiter;

   localparam int N  = 5;
   localparam int A  = 13;
   localparam int D  = 11;
   localparam int MH = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req, gnt, we_in, re_in;
   logic [N*A-1:0] waddr_in, raddr_in;
   logic [N*D-1:0] dp_in;
   logic           we_p, re_p, busy, viol, timeout, clear_err;
   logic [A-1:0]   write_addressp, read_addressp;
   logic [D-1:0]   dp;
   logic [2:0]     viol_id;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: current owner (-1 when nobody owns the port), rotation pointer, hold count, flags.
   int m_owner, m_ptr, m_hold, m_vid;
   bit m_viol, m_to;

   pix_port_arbiter #(.N_REQ(N), .SIZE_1(D), .SIZE_address_pix(A), .MAX_HOLD(MH)) dut (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt), .we_in(we_in), .re_in(re_in),
      .waddr_in(waddr_in), .raddr_in(raddr_in), .dp_in(dp_in),
      .we_p(we_p), .re_p(re_p), .write_addressp(write_addressp), .read_addressp(read_addressp),
      .dp(dp), .busy(busy), .viol(viol), .viol_id(viol_id), .timeout(timeout), .clear_err(clear_err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before 100000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_hold = 0; m_vid = 0; m_viol = 0; m_to = 0;
   endtask

   function automatic int pick(input logic [N-1:0] r);
      for (int k = 0; k < N; k++) begin
         automatic int c = (m_ptr + k) % N;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic m_en();
      return (m_owner >= 0) && req[m_owner];
   endfunction

   task automatic check_outputs();
      logic [N-1:0] eg;
      logic         en;
      #1;
      en = m_en();
      eg = (m_owner >= 0) ? N'(1) << m_owner : '0;
      chk("gnt", gnt, eg);
      chk("busy", busy, m_owner >= 0);
      chk("we_p", we_p, en && we_in[m_owner]);
      chk("re_p", re_p, en && re_in[m_owner]);
      chk("waddr", write_addressp, en ? waddr_in[m_owner*A +: A] : '0);
      chk("raddr", read_addressp, en ? raddr_in[m_owner*A +: A] : '0);
      chk("dp", dp, en ? dp_in[m_owner*D +: D] : '0);
      chk("viol", viol, m_viol);
      chk("viol_id", viol_id, m_vid);
      chk("timeout", timeout, m_to);
   endtask

   task automatic model_step();
      logic [N-1:0] eg;
      logic         en;
      int           v, w;
      en = m_en();
      eg = (m_owner >= 0) ? N'(1) << m_owner : '0;
      v = -1;
      for (int i = N - 1; i >= 0; i--)
         if ((we_in[i] | re_in[i]) && !(en && i == m_owner)) v = i;
      if (clear_err) begin
         m_viol = 0; m_vid = 0; m_to = 0;
      end else begin
         if (v >= 0 && !m_viol) begin m_viol = 1; m_vid = v; end
         if (m_owner >= 0 && m_hold >= MH && (req & ~eg) != 0) m_to = 1;
      end
      if (m_owner >= 0) begin
         if (req[m_owner]) m_hold = (m_hold < MH) ? m_hold + 1 : MH;
         else begin m_ptr = (m_owner + 1) % N; m_owner = -1; end
      end else begin
         w = pick(req);
         if (w >= 0) begin m_owner = w; m_hold = 0; end
      end
   endtask

   task automatic tick();
      check_outputs();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      req = '0; we_in = '0; re_in = '0; clear_err = 1'b0;
      waddr_in = '0; raddr_in = '0; dp_in = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      model_reset();
      check_outputs();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   int order[6];
   int start[6];
   int n_order, run, o;
   int exp_order[6] = '{0, 1, 2, 3, 4, 0};

   initial begin
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      do_reset();

      // Two requesters, conv wins from ptr=0; release gives a single dead cycle.
      req = 5'b00110;
      tick();
      chk("tp1_gnt_conv", gnt, 5'b00010);
      req = 5'b00100;
      tick();
      chk("tp1_dead_gnt", gnt, 5'b00000);
      chk("tp1_dead_we", we_p, 1'b0);
      tick();
      chk("tp1_gnt_maxp", gnt, 5'b00100);

      // Full rotation with every owner releasing after three granted cycles.
      do_reset();
      n_order = 0; run = 0;
      for (int cyc = 0; cyc < 60 && n_order < 6; cyc++) begin
         req = 5'b11111;
         if (gnt != '0) begin
            o = 0;
            for (int i = 0; i < N; i++) if (gnt[i]) o = i;
            if (run == 0) begin order[n_order] = o; start[n_order] = cyc; n_order++; end
            run++;
            if (run == 3) begin req[o] = 1'b0; run = 0; end
         end
         tick();
      end
      chk("rr_count", n_order, 6);
      for (int i = 0; i < 6 && i < n_order; i++) chk($sformatf("rr_order%0d", i), order[i], exp_order[i]);
      for (int i = 0; i < 5 && i + 1 < n_order; i++) chk($sformatf("rr_spacing%0d", i), start[i+1] - start[i], 4);

      // Ungranted write from maxp while conv owns the port.
      do_reset();
      req = 5'b00010;
      tick();
      we_in = 5'b00110;
      waddr_in[1*A +: A] = 13'd7;
      waddr_in[2*A +: A] = 13'd100;
      #1;
      chk("viol_we_conv", we_p, 1'b1);
      chk("viol_addr_conv", write_addressp, 13'd7);
      tick();
      chk("viol_set", viol, 1'b1);
      chk("viol_id_maxp", viol_id, 3'd2);
      we_in = '0;
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      chk("viol_cleared", viol, 1'b0);

      // Asynchronous reset in the middle of a dense write, after ptr has moved past 0.
      do_reset();
      req = 5'b00010;
      tick();
      req = 5'b00000;
      tick();
      req = 5'b01000;
      tick();
      we_in = 5'b01000;
      waddr_in[3*A +: A] = 13'h0123;
      #1;
      chk("rst_pre_we", we_p, 1'b1);
      rst = 1'b1;
      model_reset();
      #1;
      chk("rst_async_gnt", gnt, 5'b00000);
      chk("rst_async_we", we_p, 1'b0);
      chk("rst_async_busy", busy, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      req = 5'b10010;
      tick();
      chk("rst_ptr0_gnt", gnt, 5'b00010);

      // Hold limit: dense holds while result waits, then result holds alone.
      do_reset();
      req = 5'b01000;
      tick();
      req = 5'b11000;
      for (int i = 0; i < 10; i++) tick();
      chk("to_set", timeout, 1'b1);
      req = 5'b10000;
      clear_err = 1'b1;
      tick();
      tick();
      clear_err = 1'b0;
      chk("to_cleared", timeout, 1'b0);
      chk("to_result_gnt", gnt, 5'b10000);
      for (int i = 0; i < 10; i++) tick();
      chk("to_solo", timeout, 1'b0);

      // Signed write data passes through unchanged for the granted owner.
      do_reset();
      req = 5'b01000;
      tick();
      we_in = 5'b01000;
      waddr_in[3*A +: A] = 13'h0C40;
      dp_in[3*D +: D] = 11'(-5);
      #1;
      chk("dense_we", we_p, 1'b1);
      chk("dense_addr", write_addressp, 13'h0C40);
      chk("dense_dp", dp, 11'h7FB);
      tick();

      // Randomised traffic against the model.
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         req = req ^ (5'($urandom) & 5'($urandom));
         if ($urandom_range(0, 3) == 0) we_in = 5'($urandom) & 5'($urandom) & 5'($urandom);
         else                           we_in = gnt & 5'($urandom);
         if ($urandom_range(0, 3) == 0) re_in = 5'($urandom) & 5'($urandom) & 5'($urandom);
         else                           re_in = gnt & 5'($urandom);
         clear_err = ($urandom_range(0, 7) == 0);
         waddr_in = 65'({$urandom(), $urandom(), $urandom()});
         raddr_in = 65'({$urandom(), $urandom(), $urandom()});
         dp_in    = 55'({$urandom(), $urandom()});
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
